// File: rtl/stream_pkg.sv
// Shared stream-handshake types and the unpacker FSM state encoding.
package stream_pkg;

  // Two-state unpacker FSM: IDLE holds no word, SEND holds a word with beats pending.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } unpack_state_t;

  // One valid/ready handshake observed at a clock edge.
  typedef struct packed {
    logic valid;
    logic ready;
  } handshake_t;

  // A transfer takes place when both sides of the handshake agree.
  function automatic logic hs_fire(input handshake_t hs);
    return hs.valid & hs.ready;
  endfunction

endpackage

// File: rtl/stream_unpack_4to1_if.sv
// Upstream word bus and downstream beat bus of the 4-to-1 stream unpacker.
interface stream_unpack_4to1_if #(
  parameter int unsigned D_WIDTH = 6,
  parameter int unsigned LANES   = 4
);
  localparam int unsigned C_WIDTH = $clog2(LANES);

  logic [LANES*D_WIDTH-1:0] up_data;
  logic [C_WIDTH-1:0]       up_len;
  logic                     up_valid;
  logic                     up_ready;
  logic [D_WIDTH-1:0]       down_data;
  logic                     down_valid;
  logic                     down_last;
  logic                     down_ready;

  // Producer of words / consumer of beats (the environment around the block).
  modport master (
    output up_data, up_len, up_valid, down_ready,
    input  up_ready, down_data, down_valid, down_last
  );

  // The unpacker itself.
  modport slave (
    input  up_data, up_len, up_valid, down_ready,
    output up_ready, down_data, down_valid, down_last
  );

endinterface

// File: rtl/stream_unpack_4to1.sv
// Splits each accepted LANES-lane word into beats 0..up_len, one beat per cycle.
module stream_unpack_4to1
  import stream_pkg::*;
#(
  parameter int unsigned D_WIDTH = 6,
  parameter int unsigned LANES   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  stream_unpack_4to1_if.slave   bus
);

  localparam int unsigned C_WIDTH = $clog2(LANES);

  unpack_state_t            state;
  logic [LANES*D_WIDTH-1:0] word;
  logic [C_WIDTH-1:0]       len;
  logic [C_WIDTH-1:0]       lane;
  logic                     last;
  handshake_t               up_hs;
  handshake_t               down_hs;
  logic                     up_fire;
  logic                     down_fire;

  assign last           = (state == SEND) && (lane == len);
  assign bus.down_valid = (state == SEND);
  assign bus.down_last  = last;
  assign bus.down_data  = word[lane*D_WIDTH +: D_WIDTH];
  // Gated by rst so the block advertises no space while held in reset;
  // in SEND the new word may only enter as the last beat leaves.
  assign bus.up_ready   = rst && ((state == IDLE) || (last && bus.down_ready));

  assign up_hs.valid    = bus.up_valid;
  assign up_hs.ready    = bus.up_ready;
  assign down_hs.valid  = bus.down_valid;
  assign down_hs.ready  = bus.down_ready;
  assign up_fire        = hs_fire(up_hs);
  assign down_fire      = hs_fire(down_hs);

  // Word/length capture, lane stepping and IDLE/SEND sequencing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      word  <= '0;
      len   <= '0;
      lane  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (up_fire) begin
            word  <= bus.up_data;
            len   <= bus.up_len;
            lane  <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (down_fire) begin
            if (!last) begin
              lane <= lane + 1'b1;
            end else if (up_fire) begin
              word <= bus.up_data;
              len  <= bus.up_len;
              lane <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_unpack_4to1.sv
// Self-checking bench for stream_unpack_4to1 (D_WIDTH=6, LANES=4).
module tb_stream_unpack_4to1;

  localparam int unsigned D_WIDTH = 6;
  localparam int unsigned LANES   = 4;
  localparam int unsigned C_WIDTH = $clog2(LANES);
  localparam int unsigned W_WIDTH = LANES * D_WIDTH;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  stream_unpack_4to1_if #(.D_WIDTH(D_WIDTH), .LANES(LANES)) bus ();

  stream_unpack_4to1 #(.D_WIDTH(D_WIDTH), .LANES(LANES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W_WIDTH-1:0] pack4(input logic [D_WIDTH-1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    bus.up_data = pack4(6'h11, 6'h22, 6'h33, 6'h04);
    bus.up_len = 2'd3;
    bus.up_valid = 1'b1;
    bus.down_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (bus.up_ready !== 1'b0 || bus.down_valid !== 1'b0 || bus.down_last !== 1'b0 || bus.down_data !== 6'h00) begin
        n_err++;
        $display("FAIL reset_outputs[%0d]: got rdy=%b v=%b l=%b d=%h, want rdy=0 v=0 l=0 d=00",
                 i, bus.up_ready, bus.down_valid, bus.down_last, bus.down_data);
      end
    end
    @(negedge clk);
    bus.up_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.up_ready !== 1'b1 || bus.down_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got rdy=%b v=%b, want rdy=1 v=0", bus.up_ready, bus.down_valid);
    end
  endtask

  task automatic test_basic();
    logic [D_WIDTH-1:0] exp_lane[4];
    exp_lane = '{6'h01, 6'h15, 6'h2A, 6'h3F};
    @(negedge clk);
    bus.up_data = pack4(exp_lane[0], exp_lane[1], exp_lane[2], exp_lane[3]);
    bus.up_len = 2'd3;
    bus.up_valid = 1'b1;
    bus.down_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.up_ready !== 1'b1 || bus.down_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_idle: got rdy=%b v=%b, want rdy=1 v=0", bus.up_ready, bus.down_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.up_valid = 1'b0;
      #1;
      n_cmp++;
      if (bus.down_valid !== 1'b1 || bus.down_data !== exp_lane[i] ||
          bus.down_last !== (i == 3) || bus.up_ready !== (i == 3)) begin
        n_err++;
        $display("FAIL basic_beat%0d: got v=%b d=%h l=%b rdy=%b, want v=1 d=%h l=%b rdy=%b",
                 i, bus.down_valid, bus.down_data, bus.down_last, bus.up_ready,
                 exp_lane[i], (i == 3), (i == 3));
      end
    end
    @(negedge clk); #1;
    n_cmp++;
    if (bus.down_valid !== 1'b0 || bus.up_ready !== 1'b1) begin
      n_err++;
      $display("FAIL basic_done: got v=%b rdy=%b, want v=0 rdy=1", bus.down_valid, bus.up_ready);
    end
  endtask

  task automatic test_short();
    @(negedge clk);
    bus.up_data = pack4(6'h07, 6'h2B, 6'h1C, 6'h3D);
    bus.up_len = 2'd0;
    bus.up_valid = 1'b1;
    bus.down_ready = 1'b1;
    @(negedge clk);
    bus.up_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.down_valid !== 1'b1 || bus.down_data !== 6'h07 || bus.down_last !== 1'b1) begin
      n_err++;
      $display("FAIL short_beat: got v=%b d=%h l=%b, want v=1 d=07 l=1",
               bus.down_valid, bus.down_data, bus.down_last);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (bus.down_valid !== 1'b0 || bus.up_ready !== 1'b1) begin
        n_err++;
        $display("FAIL short_idle[%0d]: got v=%b rdy=%b, want v=0 rdy=1", i, bus.down_valid, bus.up_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [D_WIDTH-1:0] exp_d[4];
    exp_d = '{6'h0A, 6'h0B, 6'h30, 6'h31};
    @(negedge clk);
    bus.up_data = pack4(exp_d[0], exp_d[1], 6'h3E, 6'h3E);
    bus.up_len = 2'd1;
    bus.up_valid = 1'b1;
    bus.down_ready = 1'b1;
    @(negedge clk);
    bus.up_data = pack4(exp_d[2], exp_d[3], 6'h3E, 6'h3E);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.up_valid = 1'b0;
      #1;
      n_cmp++;
      if (bus.down_valid !== 1'b1 || bus.down_data !== exp_d[i] ||
          bus.down_last !== (i % 2 == 1) || bus.up_ready !== (i % 2 == 1)) begin
        n_err++;
        $display("FAIL b2b_beat%0d: got v=%b d=%h l=%b rdy=%b, want v=1 d=%h l=%b rdy=%b",
                 i, bus.down_valid, bus.down_data, bus.down_last, bus.up_ready,
                 exp_d[i], (i % 2 == 1), (i % 2 == 1));
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (bus.down_valid !== 1'b0 || bus.up_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_idle: got v=%b rdy=%b, want v=0 rdy=1", bus.down_valid, bus.up_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [D_WIDTH-1:0] exp_lane[4];
    exp_lane = '{6'h21, 6'h12, 6'h2D, 6'h1E};
    @(negedge clk);
    bus.up_data = pack4(exp_lane[0], exp_lane[1], exp_lane[2], exp_lane[3]);
    bus.up_len = 2'd3;
    bus.up_valid = 1'b1;
    bus.down_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      int unsigned idx;
      @(negedge clk);
      bus.up_valid = 1'b0;
      bus.down_ready = !(i >= 2 && i <= 4);
      idx = (i < 2) ? i : (i <= 5) ? 2 : 3;
      #1;
      n_cmp++;
      if (bus.down_valid !== 1'b1 || bus.down_data !== exp_lane[idx] || bus.down_last !== (idx == 3)) begin
        n_err++;
        $display("FAIL bp_cycle%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                 i, bus.down_valid, bus.down_data, bus.down_last, exp_lane[idx], (idx == 3));
      end
    end
    bus.down_ready = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (bus.down_valid !== 1'b0 || bus.up_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_idle: got v=%b rdy=%b, want v=0 rdy=1", bus.down_valid, bus.up_ready);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [D_WIDTH-1:0] exp_lane[4];
    exp_lane = '{6'h05, 6'h26, 6'h37, 6'h18};
    @(negedge clk);
    bus.up_data = pack4(6'h3A, 6'h3B, 6'h3C, 6'h3D);
    bus.up_len = 2'd3;
    bus.up_valid = 1'b1;
    bus.down_ready = 1'b1;
    @(negedge clk);
    bus.up_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.up_data = pack4(exp_lane[0], exp_lane[1], exp_lane[2], exp_lane[3]);
    bus.up_valid = 1'b1;
    #1;
    n_cmp++;
    if (bus.down_valid !== 1'b0 || bus.up_ready !== 1'b0 || bus.down_data !== 6'h00) begin
      n_err++;
      $display("FAIL rstmid_asserted: got v=%b rdy=%b d=%h, want v=0 rdy=0 d=00",
               bus.down_valid, bus.up_ready, bus.down_data);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.up_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (bus.down_valid !== 1'b0 || bus.up_ready !== 1'b1) begin
        n_err++;
        $display("FAIL rstmid_quiet[%0d]: got v=%b rdy=%b, want v=0 rdy=1", i, bus.down_valid, bus.up_ready);
      end
    end
    bus.up_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.up_valid = 1'b0;
      #1;
      n_cmp++;
      if (bus.down_valid !== 1'b1 || bus.down_data !== exp_lane[i] || bus.down_last !== (i == 3)) begin
        n_err++;
        $display("FAIL rstmid_beat%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                 i, bus.down_valid, bus.down_data, bus.down_last, exp_lane[i], (i == 3));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [D_WIDTH-1:0] pend[$];
    logic [W_WIDTH-1:0] w;
    logic [C_WIDTH-1:0] l;
    logic uv, dr, exp_ready, exp_valid;
    int unsigned words = 0;
    int unsigned beats = 0;
    int unsigned budget = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      uv = ($urandom_range(0, 3) != 0);
      dr = (cyc >= 700) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (cyc >= 700) uv = 1'b0;
      w = W_WIDTH'($urandom);
      l = C_WIDTH'($urandom_range(0, LANES - 1));
      @(negedge clk);
      bus.up_valid = uv;
      bus.down_ready = dr;
      bus.up_data = w;
      bus.up_len = l;
      #1;
      exp_valid = (pend.size() != 0);
      exp_ready = (pend.size() == 0) || (pend.size() == 1 && dr);
      n_cmp++;
      if (bus.up_ready !== exp_ready || bus.down_valid !== exp_valid) begin
        n_err++;
        $display("FAIL rand_hs cyc%0d: got rdy=%b v=%b, want rdy=%b v=%b",
                 cyc, bus.up_ready, bus.down_valid, exp_ready, exp_valid);
      end
      if (exp_valid) begin
        n_cmp++;
        if (bus.down_data !== pend[0] || bus.down_last !== (pend.size() == 1)) begin
          n_err++;
          $display("FAIL rand_beat cyc%0d: got d=%h l=%b, want d=%h l=%b",
                   cyc, bus.down_data, bus.down_last, pend[0], (pend.size() == 1));
        end
      end
      if (exp_valid && dr) begin
        void'(pend.pop_front());
        beats++;
      end
      if (uv && exp_ready) begin
        for (int unsigned i = 0; i <= l; i++) pend.push_back(w[i*D_WIDTH +: D_WIDTH]);
        words++;
      end
      budget = cyc;
    end
    n_cmp++;
    if (pend.size() != 0 || words == 0) begin
      n_err++;
      $display("FAIL rand_drain: got %0d beats pending, %0d words after %0d cycles, want 0 pending, >0 words",
               pend.size(), words, budget + 1);
    end
    bus.up_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
